// File: rtl/wb_ddr2_wbuf_pkg.sv
// Shared Wishbone encodings and write-buffer FSM types for the DDR2 posted-write buffer.
package wb_ddr2_wbuf_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_PASS  = 2'd2
  } wbuf_state_e;

  // A request may be posted only if it is a single-beat write.
  function automatic logic is_posted(input logic we, input logic [2:0] cti);
    return we && ((cti == CTI_CLASSIC) || (cti == CTI_EOB));
  endfunction

endpackage

// File: rtl/wb_wbuf_fifo.sv
// Synchronous FIFO holding posted {adr,dat,sel} entries; head is visible on o_rdata.
module wb_wbuf_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 68,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/wb_ddr2_wbuf.sv
// Posted-write buffer in front of the DDR2 Wishbone bridge: single-beat writes are
// acked early and drained in order; anything else flushes the buffer, then passes through.
module wb_ddr2_wbuf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic [AW-1:0]          wbs_adr_i,
  input  logic [DW-1:0]          wbs_dat_i,
  input  logic [DW/8-1:0]        wbs_sel_i,
  input  logic                   wbs_we_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic [2:0]             wbs_cti_i,
  input  logic [1:0]             wbs_bte_i,
  output logic [DW-1:0]          wbs_dat_o,
  output logic                   wbs_ack_o,
  output logic                   wbs_err_o,
  output logic [AW-1:0]          wbm_adr_o,
  output logic [DW-1:0]          wbm_dat_o,
  output logic [DW/8-1:0]        wbm_sel_o,
  output logic                   wbm_we_o,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic [2:0]             wbm_cti_o,
  output logic [1:0]             wbm_bte_o,
  input  logic [DW-1:0]          wbm_dat_i,
  input  logic                   wbm_ack_i,
  input  logic                   wbm_err_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   wr_err_o
);
  import wb_ddr2_wbuf_pkg::*;

  localparam int unsigned SW = DW / 8;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = AW + DW + SW;

  logic [1:0]    r_rst_sync;
  logic          w_rst_n;
  wbuf_state_e   r_state;
  logic          r_ack;
  logic          r_dcyc;
  logic          r_wr_err;
  logic          w_req;
  logic          w_posted;
  logic          w_push;
  logic          w_pop;
  logic          w_more;
  logic          w_pass;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  logic [EW-1:0] w_head;
  logic [AW-1:0] w_hadr;
  logic [DW-1:0] w_hdat;
  logic [SW-1:0] w_hsel;

  // Assert immediately, release two clocks after the external reset deasserts.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_rst_sync <= 2'b00;
    else             r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_req    = wbs_cyc_i && wbs_stb_i;
  assign w_posted = is_posted(wbs_we_i, wbs_cti_i);
  assign w_pass   = (r_state == ST_PASS);
  // r_ack blocks the still-asserted stb of the request being acked from a second push.
  assign w_push   = (r_state == ST_IDLE) && w_req && w_posted && !r_ack && !w_full;
  assign w_pop    = r_dcyc && (wbm_ack_i || wbm_err_i);
  assign w_more   = (w_level > LW'(1)) || w_push;
  assign {w_hadr, w_hdat, w_hsel} = w_head;

  wb_wbuf_fifo #(
    .DEPTH (DEPTH),
    .W     (EW),
    .LW    (LW)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (w_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({wbs_adr_i, wbs_dat_i, wbs_sel_i}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Mode FSM plus the registered ack, drain-cycle and sticky error flags.
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_IDLE;
      r_ack    <= 1'b0;
      r_dcyc   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_ack <= w_push;
      if (w_pop)         r_dcyc <= w_more;
      else if (!w_empty) r_dcyc <= 1'b1;
      if (w_pop && wbm_err_i) r_wr_err <= 1'b1;
      case (r_state)
        ST_IDLE:  if (w_req && !w_posted)   r_state <= ST_FLUSH;
        ST_FLUSH: if (w_empty && !r_dcyc)   r_state <= ST_PASS;
        ST_PASS:  if (!wbs_cyc_i)           r_state <= ST_IDLE;
        default:                            r_state <= ST_IDLE;
      endcase
    end
  end

  // Drain outputs are forced to zero between cycles so reset leaves the bus quiet.
  assign wbm_cyc_o = w_pass ? wbs_cyc_i : r_dcyc;
  assign wbm_stb_o = w_pass ? wbs_stb_i : r_dcyc;
  assign wbm_we_o  = w_pass ? wbs_we_i  : r_dcyc;
  assign wbm_adr_o = w_pass ? wbs_adr_i : (r_dcyc ? w_hadr : '0);
  assign wbm_dat_o = w_pass ? wbs_dat_i : (r_dcyc ? w_hdat : '0);
  assign wbm_sel_o = w_pass ? wbs_sel_i : (r_dcyc ? w_hsel : '0);
  assign wbm_cti_o = w_pass ? wbs_cti_i : (r_dcyc ? CTI_EOB : CTI_CLASSIC);
  assign wbm_bte_o = w_pass ? wbs_bte_i : BTE_LINEAR;

  assign wbs_ack_o = w_pass ? wbm_ack_i : r_ack;
  assign wbs_err_o = w_pass && wbm_err_i;
  assign wbs_dat_o = w_pass ? wbm_dat_i : '0;
  assign level_o   = w_level;
  assign wr_err_o  = r_wr_err;

endmodule

// File: doc/wb_ddr2_wbuf.md
WB_DDR2_WBUF -- requirements
Module: wb_ddr2_wbuf

Interface
REQ-001 SHALL have parameters: DEPTH, 8, posted-write entries (power of 2, 2..64); AW, 32, address width; DW, 32, data width.
REQ-002 SHALL have ports, clock and reset first:
- wb_clk_i  in  1  single clock; the only clock.
- wb_rst_n_i  in  1  reset; asynchronous, active-low.
- wbs_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  AW/DW/DW/8/1/1/1/3/2  upstream Wishbone slave request.
- wbs_dat_o/ack_o/err_o  out  DW/1/1  upstream response.
- wbm_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  AW/DW/DW/8/1/1/1/3/2  downstream master to the DDR2 Wishbone bridge.
- wbm_dat_i/ack_i/err_i  in  DW/1/1  downstream response.
- level_o  out  clog2(DEPTH)+1  current FIFO occupancy.
- wr_err_o  out  1  sticky: a posted write drew wbm_err_i.

Function
REQ-003 SHALL post write requests that are single beats (cyc&stb&we, cti 000 or 111) into a FIFO of {adr,dat,sel}, accepted only when level_o<DEPTH and wbs_ack_o=0.
REQ-004 SHALL assert wbs_ack_o for exactly one cycle, the cycle after the accepting edge; the stb seen during the ack cycle is the same request and SHALL NOT be pushed again.
REQ-005 SHALL stall a posted write while FIFO is full, with no ack, until a pop frees a slot; acceptance uses the registered level, so a pop and a full-FIFO request in the same cycle gives acceptance no earlier than the next cycle.
REQ-006 SHALL drain the FIFO head to the master port as classic cycles (cti=111, bte=00, we=1): cyc/stb held with head data until wbm_ack_i or wbm_err_i, then pop; the next entry is presented in the following cycle if one is present.
REQ-007 SHALL set wr_err_o on wbm_err_i during drain, pop and discard that entry, and hold wr_err_o until reset.
REQ-008 Push and pop in the same cycle SHALL leave level_o unchanged; pointers wrap modulo DEPTH.
REQ-009 SHALL implement FSM states IDLE, FLUSH, PASS:
- IDLE: posting and draining run concurrently; a non-posted request (any read, or a write with cti 001/010) -> FLUSH.
- FLUSH: posting is disabled and the drain continues; level=0 with no drain cycle in flight -> PASS.
- PASS: wbm_* = wbs_* combinationally; wbs_ack_o/err_o/dat_o = wbm_*; wbs_cyc_i falling -> IDLE.
REQ-010 Reads SHALL never bypass buffered writes; every earlier posted write reaches the master before any read beat.
REQ-011 wbs_err_o SHALL be 0 outside PASS; wbs_dat_o SHALL be 0 outside PASS.
REQ-012 A drain cycle in flight SHALL NOT be aborted by a new slave request.

Reset
REQ-013 Asserting wb_rst_n_i low SHALL immediately drive these outputs and state: wbs_ack_o=0, wbs_err_o=0, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, all other wbm_* outputs 0, level_o=0, wr_err_o=0, state=IDLE, FIFO pointers=0; buffered entries are discarded.
REQ-014 Reset deassertion SHALL be synchronised internally (two-flop release) before it leaves the block's registers.
REQ-015 Reset in the middle of a drain or PASS cycle SHALL drop wbm_cyc_o within the same reset assertion with no further ack to upstream.

Structure
REQ-016 CTI/BTE encodings (CLASSIC 000, CONST 001, INC 010, EOB 111; LINEAR 00) SHALL live in the shared Wishbone package and SHALL NOT be redefined locally.
REQ-017 Storage SHALL be one sub-module, wb_wbuf_fifo (synchronous FIFO, DEPTH x (AW+DW+DW/8), full/empty/level outputs, async active-low reset); the FSM and port muxing stay in wb_ddr2_wbuf.

Verification
REQ-018 Single write 0x0000_0010 <- 0x00010203, sel 0xF: wbs_ack_o 1 cycle later; level_o 0->1->0; wbm sees the same adr, dat and sel with cti=111.
REQ-019 DEPTH=8, wbm_ack_i held low, 9 back-to-back writes: 8 acked; the 9th stalls with level_o=8 until one wbm_ack_i, then is acked.
REQ-020 Posted write 0x0001_001c <- 0x04050607, then read 0x0001_001c: no wbm read cycle until drain completes; read returns 0x04050607.
REQ-021 8-beat INC write burst at 0x0002_0000: FLUSH then PASS; all 8 beats are forwarded with cti 010...111 and the FSM returns to IDLE after cyc falls.
REQ-022 wbm_err_i on the 2nd of 3 drained writes: wr_err_o goes 1 and stays 1; the 3rd write is still issued; level_o ends at 0.
REQ-023 Pulse wb_rst_n_i low with level_o=5 and a drain in flight: wbm_cyc_o=0 and level_o=0 immediately; after release, a new write is accepted normally.
